// File: rtl/wrr_packet_arbiter.sv
// rtl/wrr_packet_arbiter.sv - weighted round-robin packet arbiter onto one valid/ready stream
// A grant is held for a whole packet; each source may send weight[i] packets per round.
module wrr_packet_arbiter #(
  parameter int REQ_NUM   = 4,
  parameter int DATA_WD   = 32,
  parameter int WEIGHT_WD = 4,
  localparam int IDX_WD   = $clog2(REQ_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [IDX_WD-1:0]          cfg_idx,
  input  logic [WEIGHT_WD-1:0]       cfg_weight,
  input  logic [REQ_NUM-1:0]         s_valid,
  output logic [REQ_NUM-1:0]         s_ready,
  input  logic [REQ_NUM*DATA_WD-1:0] s_data,
  input  logic [REQ_NUM-1:0]         s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WD-1:0]         m_data,
  output logic                       m_last,
  output logic [IDX_WD-1:0]          m_src,
  output logic                       busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state;
  logic [WEIGHT_WD-1:0] weight [REQ_NUM];
  logic [WEIGHT_WD-1:0] credit [REQ_NUM];
  logic [IDX_WD-1:0]    ptr;
  logic [IDX_WD-1:0]    grant_idx;
  logic [IDX_WD-1:0]    pick_idx;
  logic [IDX_WD-1:0]    next_ptr;
  logic [REQ_NUM-1:0]   eligible;
  logic [REQ_NUM-1:0]   reloadable;
  logic                 any_eligible;
  logic                 beat_done;

  function automatic logic [IDX_WD-1:0] wrap_add(input logic [IDX_WD-1:0] a, input int b);
    int s;
    s = (int'(a) + b) % REQ_NUM;
    return IDX_WD'(s);
  endfunction

  always_comb begin
    eligible   = '0;
    reloadable = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      eligible[i]   = s_valid[i] && (credit[i] != '0) && (weight[i] != '0);
      reloadable[i] = s_valid[i] && (weight[i] != '0);
    end
  end

  // Rotating priority scan starting at ptr; the first hit wins.
  always_comb begin
    any_eligible = 1'b0;
    pick_idx     = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (!any_eligible && eligible[wrap_add(ptr, k)]) begin
        any_eligible = 1'b1;
        pick_idx     = wrap_add(ptr, k);
      end
    end
  end

  // The last credit moves priority on; otherwise the grantee keeps it.
  assign next_ptr = (credit[grant_idx] == WEIGHT_WD'(1)) ? wrap_add(grant_idx, 1) : grant_idx;

  assign busy = (state == XFER);

  always_comb begin
    m_valid = 1'b0;
    s_ready = '0;
    m_data  = s_data[grant_idx*DATA_WD +: DATA_WD];
    m_last  = (state == XFER) && s_last[grant_idx];
    if (state == XFER && !rst) begin
      m_valid            = s_valid[grant_idx];
      s_ready[grant_idx] = m_ready;
    end
  end

  assign beat_done = m_valid && m_ready && m_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      m_src     <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        weight[i] <= WEIGHT_WD'(1);
        credit[i] <= WEIGHT_WD'(1);
      end
    end else begin
      if (cfg_we && (int'(cfg_idx) < REQ_NUM)) begin
        weight[cfg_idx] <= cfg_weight;
      end
      case (state)
        IDLE: begin
          if (any_eligible) begin
            grant_idx <= pick_idx;
            m_src     <= pick_idx;
            state     <= XFER;
          end else if (|reloadable) begin
            for (int i = 0; i < REQ_NUM; i++) begin
              credit[i] <= weight[i];
            end
          end
        end
        XFER: begin
          if (beat_done) begin
            credit[grant_idx] <= credit[grant_idx] - WEIGHT_WD'(1);
            ptr               <= next_ptr;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// tb/tb_wrr_packet_arbiter.sv - self-checking bench for wrr_packet_arbiter
module tb_wrr_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [WW-1:0]   cfg_weight;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_last;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [IW-1:0]   m_src;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  int mdl_w [N];
  int mdl_cred [N];
  int mdl_ptr  = 0;
  int mdl_g    = 0;
  int mdl_src  = 0;
  bit mdl_xfer = 0;

  int got_src [$];
  int got_cyc [$];

  wrr_packet_arbiter #(.REQ_NUM(N), .DATA_WD(DW), .WEIGHT_WD(WW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: advance one clock of the arbitration rules using the inputs now applied.
  task automatic model_step();
    int pick;
    bit any;
    if (rst) begin
      mdl_xfer = 0; mdl_ptr = 0; mdl_src = 0; mdl_g = 0;
      for (int i = 0; i < N; i++) begin mdl_w[i] = 1; mdl_cred[i] = 1; end
    end else begin
      if (!mdl_xfer) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && s_valid[(mdl_ptr + k) % N] && mdl_cred[(mdl_ptr + k) % N] > 0
              && mdl_w[(mdl_ptr + k) % N] > 0)
            pick = (mdl_ptr + k) % N;
        end
        if (pick >= 0) begin
          mdl_g = pick; mdl_src = pick; mdl_xfer = 1;
        end else begin
          any = 0;
          for (int i = 0; i < N; i++) if (s_valid[i] && mdl_w[i] > 0) any = 1;
          if (any) for (int i = 0; i < N; i++) mdl_cred[i] = mdl_w[i];
        end
      end else if (s_valid[mdl_g] && m_ready && s_last[mdl_g]) begin
        mdl_cred[mdl_g] = mdl_cred[mdl_g] - 1;
        mdl_ptr  = (mdl_cred[mdl_g] == 0) ? (mdl_g + 1) % N : mdl_g;
        mdl_xfer = 0;
      end
      if (cfg_we) mdl_w[cfg_idx] = int'(cfg_weight);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = '0; s_last = '0; cfg_we = 1'b0; m_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int w);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_weight = WW'(w);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic run_collect(input int ncyc);
    got_src.delete();
    got_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      #2;
      if (m_valid && m_ready) begin
        got_src.push_back(int'(m_src));
        got_cyc.push_back(c);
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = '1; s_last = '1; m_ready = 1'b1; cfg_we = 1'b0;
    cycle();
    #2;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b expected 0", m_valid); end
    n_cmp++; if (s_ready !== 4'b0) begin n_bad++; $display("FAIL rst_s_ready got %b expected 0000", s_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b expected 0", busy); end
    n_cmp++; if (m_src !== 2'd0) begin n_bad++; $display("FAIL rst_m_src got %0d expected 0", m_src); end
    cycle();
    rst = 1'b0; s_valid = '0;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got %b expected 0", busy); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_m_valid got %b expected 0", m_valid); end
    cycle();
  endtask

  task automatic test_equal_weights();
    int e;
    do_reset();
    s_valid = '1; s_last = '1; m_ready = 1'b1;
    run_collect(30);
    n_cmp++;
    if (got_src.size() < 12) begin
      n_bad++; $display("FAIL eq_count got %0d expected >=12", got_src.size());
    end else begin
      n_cmp++; if (got_cyc[0] !== 1) begin n_bad++; $display("FAIL eq_first got %0d expected 1", got_cyc[0]); end
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (got_src[k] !== k % 4) begin n_bad++; $display("FAIL eq_order[%0d] got %0d expected %0d", k, got_src[k], k % 4); end
      end
      for (int k = 1; k < 12; k++) begin
        e = (k % 4 == 0) ? 3 : 2;
        n_cmp++;
        if (got_cyc[k] - got_cyc[k-1] !== e) begin
          n_bad++; $display("FAIL eq_gap[%0d] got %0d expected %0d", k, got_cyc[k] - got_cyc[k-1], e);
        end
      end
    end
  endtask

  task automatic test_weights();
    int exp_seq [18] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
    do_reset();
    cfg_write(0, 3); cfg_write(1, 1); cfg_write(2, 2); cfg_write(3, 1);
    s_valid = '1; s_last = '1; m_ready = 1'b1;
    run_collect(50);
    n_cmp++;
    if (got_src.size() < 18) begin
      n_bad++; $display("FAIL wt_count got %0d expected >=18", got_src.size());
    end else begin
      for (int k = 0; k < 18; k++) begin
        n_cmp++;
        if (got_src[k] !== exp_seq[k]) begin n_bad++; $display("FAIL wt_order[%0d] got %0d expected %0d", k, got_src[k], exp_seq[k]); end
      end
    end
  endtask

  task automatic test_long_packet();
    int b1 = 0;
    int t_last = -1;
    int t_g0 = -1;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      s_valid[1] = (b1 < 4);
      s_data[1*DW +: DW] = 32'hB100_0000 + 32'(b1);
      s_last[1] = (b1 == 3);
      s_valid[0] = (c >= 1);
      s_data[0 +: DW] = 32'hA0A0_A0A0;
      s_last[0] = 1'b1;
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      #2;
      if (b1 < 4) begin
        n_cmp++; if (s_ready[0] !== 1'b0) begin n_bad++; $display("FAIL lp_ready0 cyc %0d got %b expected 0", c, s_ready[0]); end
      end
      if (m_valid && m_ready && m_src == 2'd1) begin
        n_cmp++;
        if (m_data !== 32'hB100_0000 + 32'(b1)) begin n_bad++; $display("FAIL lp_data beat %0d got %h expected %h", b1, m_data, 32'hB100_0000 + 32'(b1)); end
        n_cmp++;
        if (m_last !== (b1 == 3)) begin n_bad++; $display("FAIL lp_last beat %0d got %b expected %b", b1, m_last, (b1 == 3)); end
        if (b1 == 3) t_last = c;
        b1++;
      end
      if (t_g0 < 0 && t_last >= 0 && busy && m_src == 2'd0) t_g0 = c;
      cycle();
    end
    n_cmp++; if (b1 !== 4) begin n_bad++; $display("FAIL lp_beats got %0d expected 4", b1); end
    n_cmp++; if (t_g0 !== t_last + 2) begin n_bad++; $display("FAIL lp_src0_grant got cyc %0d expected %0d", t_g0, t_last + 2); end
  endtask

  task automatic test_zero_weight();
    int twos = 0;
    bit pair = 0;
    do_reset();
    cfg_write(2, 0);
    s_valid = 4'b1110; s_last = '1; m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #2;
      n_cmp++;
      if (s_ready[2] !== 1'b0 || (busy && m_src == 2'd2)) begin
        n_bad++; $display("FAIL zw_off cyc %0d got s_ready[2]=%b m_src=%0d expected no grant to 2", c, s_ready[2], m_src);
      end
      cycle();
    end
    s_valid = '0;
    repeat (3) cycle();
    cfg_write(2, 2);
    s_valid = 4'b1110;
    run_collect(40);
    for (int k = 0; k < got_src.size(); k++) begin
      if (got_src[k] == 2) twos++;
      if (k > 0 && got_src[k] == 2 && got_src[k-1] == 2) pair = 1;
    end
    n_cmp++; if (twos < 2) begin n_bad++; $display("FAIL zw_on_count got %0d expected >=2", twos); end
    n_cmp++; if (pair !== 1'b1) begin n_bad++; $display("FAIL zw_on_pair got %b expected 1", pair); end
  endtask

  task automatic test_reset_mid_packet();
    bit seen = 0;
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(i, 3);
    s_valid = 4'b1000; s_last = '0; s_data[3*DW +: DW] = 32'h0000_00C3; m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (m_valid && m_ready) seen = 1;
      cycle();
      if (seen) break;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rm_start got %b expected 1", seen); end
    rst = 1'b1;
    #2;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rm_in_m_valid got %b expected 0", m_valid); end
    n_cmp++; if (s_ready !== 4'b0) begin n_bad++; $display("FAIL rm_in_s_ready got %b expected 0000", s_ready); end
    cycle();
    rst = 1'b0; s_valid = '1; s_last = '1;
    #2;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rm_m_valid got %b expected 0", m_valid); end
    n_cmp++; if (s_ready !== 4'b0) begin n_bad++; $display("FAIL rm_s_ready got %b expected 0000", s_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %b expected 0", busy); end
    n_cmp++; if (m_src !== 2'd0) begin n_bad++; $display("FAIL rm_m_src got %0d expected 0", m_src); end
    cycle();
    run_collect(20);
    n_cmp++;
    if (got_src.size() < 8) begin
      n_bad++; $display("FAIL rm_count got %0d expected >=8", got_src.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (got_src[k] !== k % 4) begin n_bad++; $display("FAIL rm_order[%0d] got %0d expected %0d", k, got_src[k], k % 4); end
      end
    end
  endtask

  task automatic test_single_source();
    int e;
    do_reset();
    cfg_write(0, 2);
    s_valid = 4'b0001; s_last = '1; m_ready = 1'b1;
    run_collect(30);
    n_cmp++;
    if (got_src.size() < 7) begin
      n_bad++; $display("FAIL ss_count got %0d expected >=7", got_src.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        n_cmp++;
        if (got_src[k] !== 0) begin n_bad++; $display("FAIL ss_src[%0d] got %0d expected 0", k, got_src[k]); end
      end
      for (int k = 1; k < 7; k++) begin
        e = (k % 2 == 1) ? 3 : 2;
        n_cmp++;
        if (got_cyc[k] - got_cyc[k-1] !== e) begin
          n_bad++; $display("FAIL ss_gap[%0d] got %0d expected %0d", k, got_cyc[k] - got_cyc[k-1], e);
        end
      end
    end
  endtask

  task automatic test_random();
    int beat [N];
    int len [N];
    int pkt [N];
    bit exp_mv;
    logic [N-1:0] exp_sr;
    do_reset();
    for (int i = 0; i < N; i++) begin
      cfg_write(i, $urandom_range(0, 3));
      beat[i] = 0; pkt[i] = 0; len[i] = $urandom_range(1, 4);
    end
    for (int c = 0; c < 2000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cfg_we     = ($urandom_range(0, 19) == 0);
      cfg_idx    = IW'($urandom_range(0, N - 1));
      cfg_weight = WW'($urandom_range(0, 3));
      m_ready    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        s_data[i*DW +: DW] = {8'(i), 16'(pkt[i]), 8'(beat[i])};
        s_last[i] = (beat[i] == len[i] - 1);
      end
      #2;
      exp_mv = !rst && mdl_xfer && s_valid[mdl_g];
      exp_sr = (!rst && mdl_xfer && m_ready) ? N'(1 << mdl_g) : '0;
      n_cmp++; if (busy !== mdl_xfer) begin n_bad++; $display("FAIL rnd_busy cyc %0d got %b expected %b", c, busy, mdl_xfer); end
      n_cmp++; if (m_valid !== exp_mv) begin n_bad++; $display("FAIL rnd_m_valid cyc %0d got %b expected %b", c, m_valid, exp_mv); end
      n_cmp++; if (s_ready !== exp_sr) begin n_bad++; $display("FAIL rnd_s_ready cyc %0d got %b expected %b", c, s_ready, exp_sr); end
      n_cmp++; if (int'(m_src) !== mdl_src) begin n_bad++; $display("FAIL rnd_m_src cyc %0d got %0d expected %0d", c, m_src, mdl_src); end
      if (exp_mv) begin
        n_cmp++;
        if (m_data !== s_data[mdl_g*DW +: DW]) begin n_bad++; $display("FAIL rnd_m_data cyc %0d got %h expected %h", c, m_data, s_data[mdl_g*DW +: DW]); end
        n_cmp++;
        if (m_last !== s_last[mdl_g]) begin n_bad++; $display("FAIL rnd_m_last cyc %0d got %b expected %b", c, m_last, s_last[mdl_g]); end
      end
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && exp_sr[i]) begin
          if (s_last[i]) begin beat[i] = 0; pkt[i]++; len[i] = $urandom_range(1, 4); end
          else beat[i]++;
        end
      end
      cycle();
    end
    rst = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_equal_weights();
    test_weights();
    test_long_packet();
    test_zero_weight();
    test_reset_mid_packet();
    test_single_source();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
